sprite_cmd_queue: RTL and testbench

//  Buffers sprite and background update commands from the game processor in a FIFO.

---
 rtl/sprite_cmd_queue.sv | 178 +++++++++++++++++
 tb/tb_sprite_cmd_queue.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_cmd_queue.sv
// Command FIFO between the game processor and the VGA sprite/background ports.
// Commands replay only while vsync is active (tear-free updates); also raises a vblank interrupt.
module sprite_cmd_queue #(
    parameter int FIFO_DEPTH = 8,
    parameter bit VS_ACT_LOW = 1'b1
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [4:0] cmd_sel,
    input  logic [9:0] cmd_x,
    input  logic [8:0] cmd_y,
    input  logic [1:0] cmd_arg,
    input  logic       vsync,
    output logic [4:0] sprite_sel,
    output logic [9:0] sprite_x,
    output logic [8:0] sprite_y,
    output logic       sprite_vis,
    output logic       sprite_pos,
    output logic       sprite_attr,
    output logic       bck_ch_active,
    output logic [1:0] bck_sel,
    output logic       vblank_irq,
    output logic [6:0] q_count,
    output logic       bad_op
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [1:0] OP_POS = 2'b00;
    localparam logic [1:0] OP_VIS = 2'b01;
    localparam logic [1:0] OP_BCK = 2'b10;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_GAP = 2'd2} state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] sel;
        logic [9:0] x;
        logic [8:0] y;
        logic [1:0] arg;
    } cmd_t;

    cmd_t          mem_q [FIFO_DEPTH];
    cmd_t          head;
    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [6:0]    count_q, count_d;
    logic [4:0]    sel_q, sel_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic          vis_q, vis_d;
    logic          pos_q, pos_d;
    logic          attr_q, attr_d;
    logic          bck_q, bck_d;
    logic [1:0]    bck_sel_q, bck_sel_d;
    logic          irq_q, irq_d;
    logic          vs_prev_q, vs_prev_d;
    logic          bad_q, bad_d;
    logic          vs_act, push, pop;

    assign vs_act    = vsync ^ VS_ACT_LOW;
    assign cmd_ready = (count_q != 7'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // The pop happens on the edge that enters ISSUE, so the strobe and data leave registered.
    assign pop       = (state_q != S_ISSUE) && vs_act && (count_q != 7'd0);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves a latch.
        state_d   = state_q;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        sel_d     = sel_q;
        x_d       = x_q;
        y_d       = y_q;
        vis_d     = vis_q;
        bck_sel_d = bck_sel_q;
        pos_d     = 1'b0;
        attr_d    = 1'b0;
        bck_d     = 1'b0;
        bad_d     = bad_q;
        irq_d     = vs_act && !vs_prev_q;
        vs_prev_d = vs_act;

        if (push && !pop) begin
            count_d = count_q + 7'd1;
        end else if (pop && !push) begin
            count_d = count_q - 7'd1;
        end

        unique case (state_q)
            S_IDLE, S_GAP: state_d = pop ? S_ISSUE : S_IDLE;
            S_ISSUE:       state_d = S_GAP;
            default:       state_d = S_IDLE;
        endcase

        if (pop) begin
            unique case (head.op)
                OP_POS: begin
                    sel_d = head.sel;
                    x_d   = head.x;
                    y_d   = head.y;
                    pos_d = 1'b1;
                end
                OP_VIS: begin
                    sel_d  = head.sel;
                    vis_d  = head.arg[0];
                    attr_d = 1'b1;
                end
                OP_BCK: begin
                    bck_sel_d = head.arg;
                    bck_d     = 1'b1;
                end
                default: bad_d = 1'b1;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk_25mhz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: cmd_op, sel: cmd_sel, x: cmd_x, y: cmd_y, arg: cmd_arg};
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sel_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            vis_q     <= 1'b0;
            pos_q     <= 1'b0;
            attr_q    <= 1'b0;
            bck_q     <= 1'b0;
            bck_sel_q <= '0;
            irq_q     <= 1'b0;
            vs_prev_q <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sel_q     <= sel_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vis_q     <= vis_d;
            pos_q     <= pos_d;
            attr_q    <= attr_d;
            bck_q     <= bck_d;
            bck_sel_q <= bck_sel_d;
            irq_q     <= irq_d;
            vs_prev_q <= vs_prev_d;
            bad_q     <= bad_d;
        end
    end

    assign sprite_sel    = sel_q;
    assign sprite_x      = x_q;
    assign sprite_y      = y_q;
    assign sprite_vis    = vis_q;
    assign sprite_pos    = pos_q;
    assign sprite_attr   = attr_q;
    assign bck_ch_active = bck_q;
    assign bck_sel       = bck_sel_q;
    assign vblank_irq    = irq_q;
    assign q_count       = count_q;
    assign bad_op        = bad_q;

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Directed bench for sprite_cmd_queue (FIFO_DEPTH=8, active-low vsync).
// Inputs change and outputs are sampled on the falling edge of clk_25mhz.
module tb_sprite_cmd_queue;

    logic       clk_25mhz = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [4:0] cmd_sel = '0;
    logic [9:0] cmd_x = '0;
    logic [8:0] cmd_y = '0;
    logic [1:0] cmd_arg = '0;
    logic       vsync = 1'b1;
    logic [4:0] sprite_sel;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic       sprite_vis, sprite_pos, sprite_attr, bck_ch_active, vblank_irq, bad_op;
    logic [1:0] bck_sel;
    logic [6:0] q_count;

    int checks = 0;
    int failures = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    sprite_cmd_queue #(.FIFO_DEPTH(8), .VS_ACT_LOW(1'b1)) dut (
        .clk_25mhz(clk_25mhz), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_arg(cmd_arg),
        .vsync(vsync), .sprite_sel(sprite_sel), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_vis(sprite_vis), .sprite_pos(sprite_pos), .sprite_attr(sprite_attr),
        .bck_ch_active(bck_ch_active), .bck_sel(bck_sel), .vblank_irq(vblank_irq),
        .q_count(q_count), .bad_op(bad_op)
    );

    task automatic tick();
        @(negedge clk_25mhz);
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [4:0] sel, input logic [9:0] x,
                             input logic [8:0] y, input logic [1:0] arg);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_sel = sel; cmd_x = x; cmd_y = y; cmd_arg = arg;
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b1; cmd_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if ({sprite_pos, sprite_attr, bck_ch_active, vblank_irq, bad_op} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000",
                     {sprite_pos, sprite_attr, bck_ch_active, vblank_irq, bad_op});
        end
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        checks++;
        if (q_count !== 7'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", q_count); end
        checks++;
        if ({sprite_sel, sprite_x, sprite_y, bck_sel} !== 26'd0) begin
            failures++; $display("FAIL reset_data: got %h want 0", {sprite_sel, sprite_x, sprite_y, bck_sel});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_pos();
        drive_cmd(2'b00, 5'd3, 10'd100, 9'd50, 2'd0);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (q_count !== 7'd1) begin failures++; $display("FAIL single_count: got %0d want 1", q_count); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (sprite_pos !== 1'b0) begin failures++; $display("FAIL single_no_strobe: got %b want 0", sprite_pos); end
        end
        vsync = 1'b0;
        tick();
        checks++;
        if (vblank_irq !== 1'b1) begin failures++; $display("FAIL single_irq_on: got %b want 1", vblank_irq); end
        checks++;
        if ({sprite_pos, sprite_sel, sprite_x, sprite_y} !== {1'b1, 5'd3, 10'd100, 9'd50}) begin
            failures++;
            $display("FAIL single_strobe: got pos=%b sel=%0d x=%0d y=%0d want 1/3/100/50",
                     sprite_pos, sprite_sel, sprite_x, sprite_y);
        end
        tick();
        checks++;
        if ({vblank_irq, sprite_pos} !== 2'b00) begin
            failures++; $display("FAIL single_after: got irq=%b pos=%b want 0 0", vblank_irq, sprite_pos);
        end
        checks++;
        if (q_count !== 7'd0) begin failures++; $display("FAIL single_drained: got %0d want 0", q_count); end
        vsync = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_full();
        int k;
        for (int i = 0; i < 8; i++) begin
            drive_cmd(2'b00, 5'(i), 10'(i * 10 + 1), 9'(i + 2), 2'd0);
            tick();
        end
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
        checks++;
        if (q_count !== 7'd8) begin failures++; $display("FAIL full_count: got %0d want 8", q_count); end
        drive_cmd(2'b00, 5'd31, 10'd999, 9'd9, 2'd0);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (q_count !== 7'd8) begin failures++; $display("FAIL full_ninth: got %0d want 8", q_count); end
        vsync = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (sprite_pos !== ((c % 2 == 1) && (c <= 15))) begin
                failures++; $display("FAIL full_strobe_c%0d: got %b want %b", c, sprite_pos, (c % 2 == 1) && (c <= 15));
            end
            if ((c % 2 == 1) && (c <= 15)) begin
                k = (c - 1) / 2;
                checks++;
                if ({sprite_sel, sprite_x, sprite_y} !== {5'(k), 10'(k * 10 + 1), 9'(k + 2)}) begin
                    failures++;
                    $display("FAIL full_order_%0d: got sel=%0d x=%0d y=%0d want %0d/%0d/%0d",
                             k, sprite_sel, sprite_x, sprite_y, k, k * 10 + 1, k + 2);
                end
            end
        end
        checks++;
        if ({cmd_ready, q_count} !== {1'b1, 7'd0}) begin
            failures++; $display("FAIL full_empty: got ready=%b count=%0d want 1/0", cmd_ready, q_count);
        end
        vsync = 1'b1;
        tick();
    endtask

    task automatic test_partial_drain();
        logic [1:0] ops [6];
        logic [4:0] sels [6];
        ops  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        sels = '{5'd20, 5'd21, 5'd22, 5'd9, 5'd23, 5'd24};
        for (int i = 0; i < 6; i++) begin
            drive_cmd(ops[i], sels[i], 10'(200 + i), 9'(100 + i), 2'd1);
            tick();
        end
        cmd_valid = 1'b0;
        vsync = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (sprite_pos !== (c == 1 || c == 3 || c == 5)) begin
                failures++; $display("FAIL partial_strobe_c%0d: got %b want %b", c, sprite_pos, c == 1 || c == 3 || c == 5);
            end
            if (c == 1 || c == 3 || c == 5) begin
                checks++;
                if (sprite_sel !== sels[(c - 1) / 2]) begin
                    failures++; $display("FAIL partial_sel_c%0d: got %0d want %0d", c, sprite_sel, sels[(c - 1) / 2]);
                end
            end
            if (c == 5) vsync = 1'b1;
        end
        checks++;
        if (q_count !== 7'd3) begin failures++; $display("FAIL partial_left: got %0d want 3", q_count); end
        vsync = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if ({vblank_irq, sprite_attr, sprite_pos, sprite_sel, sprite_vis} !== {3'b110, 5'd9, 1'b1}) begin
                    failures++;
                    $display("FAIL partial_vis: got irq=%b attr=%b pos=%b sel=%0d vis=%b want 1 1 0 9 1",
                             vblank_irq, sprite_attr, sprite_pos, sprite_sel, sprite_vis);
                end
            end else if (c == 3 || c == 5) begin
                checks++;
                if ({sprite_pos, sprite_attr, sprite_sel, sprite_x, sprite_vis} !==
                    {2'b10, (c == 3) ? 5'd23 : 5'd24, (c == 3) ? 10'd204 : 10'd205, 1'b1}) begin
                    failures++;
                    $display("FAIL partial_resume_c%0d: got pos=%b attr=%b sel=%0d x=%0d vis=%b",
                             c, sprite_pos, sprite_attr, sprite_sel, sprite_x, sprite_vis);
                end
            end else begin
                checks++;
                if ({sprite_pos, sprite_attr} !== 2'b00) begin
                    failures++; $display("FAIL partial_quiet_c%0d: got %b%b want 00", c, sprite_pos, sprite_attr);
                end
            end
        end
        vsync = 1'b1;
        tick();
    endtask

    task automatic test_bck_bad_op();
        drive_cmd(2'b10, 5'd0, 10'd0, 9'd0, 2'd2);
        tick();
        drive_cmd(2'b11, 5'd5, 10'd7, 9'd7, 2'd1);
        tick();
        cmd_valid = 1'b0;
        vsync = 1'b0;
        tick();
        checks++;
        if ({bck_ch_active, bck_sel, sprite_pos, sprite_attr, bad_op} !== {1'b1, 2'd2, 3'b000}) begin
            failures++;
            $display("FAIL bck_strobe: got bck=%b sel=%0d pos=%b attr=%b bad=%b want 1 2 0 0 0",
                     bck_ch_active, bck_sel, sprite_pos, sprite_attr, bad_op);
        end
        tick();
        tick();
        checks++;
        if ({sprite_pos, sprite_attr, bck_ch_active} !== 3'b000) begin
            failures++; $display("FAIL bad_no_strobe: got %b%b%b want 000", sprite_pos, sprite_attr, bck_ch_active);
        end
        checks++;
        if (bad_op !== 1'b1) begin failures++; $display("FAIL bad_set: got %b want 1", bad_op); end
        checks++;
        if ({sprite_sel, bck_sel, q_count} !== {5'd24, 2'd2, 7'd0}) begin
            failures++; $display("FAIL bad_hold: got sel=%0d bck=%0d count=%0d want 24/2/0", sprite_sel, bck_sel, q_count);
        end
        vsync = 1'b1;
        repeat (3) tick();
        checks++;
        if (bad_op !== 1'b1) begin failures++; $display("FAIL bad_sticky: got %b want 1", bad_op); end
    endtask

    task automatic test_back_to_back();
        vsync = 1'b0;
        repeat (2) tick();
        drive_cmd(2'b00, 5'd1, 10'd11, 9'd12, 2'd0);
        tick();
        drive_cmd(2'b00, 5'd2, 10'd21, 9'd22, 2'd0);
        checks++;
        if ({sprite_pos, q_count} !== {1'b0, 7'd1}) begin
            failures++; $display("FAIL b2b_n1: got pos=%b count=%0d want 0/1", sprite_pos, q_count);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({sprite_pos, sprite_sel, sprite_x, q_count} !== {1'b1, 5'd1, 10'd11, 7'd1}) begin
            failures++;
            $display("FAIL b2b_latency: got pos=%b sel=%0d x=%0d count=%0d want 1/1/11/1",
                     sprite_pos, sprite_sel, sprite_x, q_count);
        end
        tick();
        checks++;
        if (sprite_pos !== 1'b0) begin failures++; $display("FAIL b2b_gap: got %b want 0", sprite_pos); end
        tick();
        checks++;
        if ({sprite_pos, sprite_sel, sprite_y, q_count} !== {1'b1, 5'd2, 9'd22, 7'd0}) begin
            failures++;
            $display("FAIL b2b_second: got pos=%b sel=%0d y=%0d count=%0d want 1/2/22/0",
                     sprite_pos, sprite_sel, sprite_y, q_count);
        end
        vsync = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 4; i++) begin
            drive_cmd(2'b00, 5'(10 + i), 10'(300 + i), 9'(30 + i), 2'd0);
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (q_count !== 7'd4) begin failures++; $display("FAIL rstd_fill: got %0d want 4", q_count); end
        vsync = 1'b0;
        tick();
        checks++;
        if ({sprite_pos, sprite_sel} !== {1'b1, 5'd10}) begin
            failures++; $display("FAIL rstd_first: got pos=%b sel=%0d want 1/10", sprite_pos, sprite_sel);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({sprite_pos, sprite_attr, bck_ch_active, vblank_irq, bad_op, cmd_ready, q_count, sprite_sel} !==
            {6'b000001, 7'd0, 5'd0}) begin
            failures++;
            $display("FAIL rstd_cleared: got pos=%b attr=%b bck=%b irq=%b bad=%b ready=%b count=%0d sel=%0d",
                     sprite_pos, sprite_attr, bck_ch_active, vblank_irq, bad_op, cmd_ready, q_count, sprite_sel);
        end
        tick();
        checks++;
        if (vblank_irq !== 1'b1) begin failures++; $display("FAIL rstd_irq: got %b want 1", vblank_irq); end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({sprite_pos, q_count} !== {1'b0, 7'd0}) begin
                failures++; $display("FAIL rstd_quiet: got pos=%b count=%0d want 0/0", sprite_pos, q_count);
            end
        end
        drive_cmd(2'b00, 5'd30, 10'd1, 9'd1, 2'd0);
        tick();
        drive_cmd(2'b00, 5'd31, 10'd2, 9'd2, 2'd0);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({sprite_pos, sprite_sel, q_count} !== {1'b1, 5'd30, 7'd1}) begin
            failures++;
            $display("FAIL rstd_push_pop: got pos=%b sel=%0d count=%0d want 1/30/1", sprite_pos, sprite_sel, q_count);
        end
        repeat (2) tick();
        checks++;
        if ({sprite_pos, sprite_sel, q_count} !== {1'b1, 5'd31, 7'd0}) begin
            failures++;
            $display("FAIL rstd_last: got pos=%b sel=%0d count=%0d want 1/31/0", sprite_pos, sprite_sel, q_count);
        end
        vsync = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_pos();
        test_full();
        test_partial_drain();
        test_bck_bad_op();
        test_back_to_back();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
